// File: rtl/display_pkg.sv
// Shared sizing helpers for the multiplexed seven-segment display path.
package display_pkg;

  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned OH_W       = 4;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [OH_W-1:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/next_digit_sel.sv
// Circular priority search: next enabled digit after cur_idx, modulo N_DIGITS.
module next_digit_sel
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned IDX_W    = idx_w(N_DIGITS)
) (
  input  logic [IDX_W-1:0]    cur_idx,
  input  logic [N_DIGITS-1:0] mask,
  output logic [IDX_W-1:0]    nxt_idx,
  output logic                wrap,
  output logic                none
);

  logic        found;
  int unsigned cand;

  // Distance k = N_DIGITS lands back on cur_idx, covering the single-digit case.
  always_comb begin
    nxt_idx = cur_idx;
    wrap    = 1'b0;
    none    = (mask == '0);
    found   = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k <= N_DIGITS; k++) begin
      cand = 32'(cur_idx) + k;
      if (cand >= N_DIGITS) cand = cand - N_DIGITS;
      if (!found && (|(mask & N_DIGITS'(onehot(OH_W'(cand)))))) begin
        found   = 1'b1;
        nxt_idx = IDX_W'(cand);
        wrap    = (32'(cur_idx) + k >= N_DIGITS);
      end
    end
  end

endmodule

// File: rtl/digit_scan_counter.sv
// Digit-select scanner: refresh prescaler, masked circular index, anode strobes.
module digit_scan_counter
  import display_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned PRESCALE = 100_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           clr,
  input  logic [N_DIGITS-1:0]            digit_mask,
  output logic [idx_w(N_DIGITS)-1:0]     cuenta,
  output logic [N_DIGITS-1:0]            anode_n,
  output logic                           tick,
  output logic                           frame_done
);

  localparam int unsigned IDX_W = idx_w(N_DIGITS);
  localparam int unsigned PW    = idx_w(PRESCALE);

  logic [PW-1:0]    pcnt;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] cuenta_next;
  logic             wrap;
  logic             none;
  logic             last_slot;
  logic             advance;

  next_digit_sel #(
    .N_DIGITS (N_DIGITS),
    .IDX_W    (IDX_W)
  ) u_sel (
    .cur_idx (cuenta),
    .mask    (digit_mask),
    .nxt_idx (nxt_idx),
    .wrap    (wrap),
    .none    (none)
  );

  assign last_slot = (pcnt == PW'(PRESCALE - 1));
  assign advance   = en & ~clr & last_slot;

  always_comb begin
    cuenta_next = cuenta;
    if (clr)                   cuenta_next = '0;
    else if (advance && !none) cuenta_next = nxt_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt       <= '0;
      cuenta     <= '0;
      anode_n    <= '1;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (clr)     pcnt <= '0;
      else if (en) pcnt <= last_slot ? '0 : pcnt + PW'(1);
      cuenta     <= cuenta_next;
      tick       <= advance;
      frame_done <= advance & ~none & wrap;
      // Anodes follow the mask every cycle so a masked digit blanks without waiting for a tick.
      anode_n    <= ~(N_DIGITS'(onehot(OH_W'(cuenta_next))) & digit_mask);
    end
  end

endmodule
